// File: rtl/w0rm_core_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | w0rm_core_regfile_wb_arbiter                                               |
// | Arbitrates writeback sources onto the single register-file write port and |
// | tracks pending writes in busy_mask. Optional: W0RM_WB_ARB_FIXED_PRIORITY_EN|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module w0rm_core_regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int NUM_REQ       = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          rsv_valid,
  input  logic [ADDR_WIDTH-1:0]         rsv_addr,
  output logic                          rf_write_enable,
  output logic [ADDR_WIDTH-1:0]         rf_write_addr,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  output logic [1:0]                    grant_id,
  output logic [NUM_REGISTERS-1:0]      busy_mask
);

  localparam logic [NUM_REGISTERS-1:0] REG_LSB = NUM_REGISTERS'(1);

  logic                     gnt_found;
  logic [NUM_REQ-1:0]       gnt_onehot;
  logic [1:0]               gnt_idx;
  logic [ADDR_WIDTH-1:0]    gnt_addr;
  logic [DATA_WIDTH-1:0]    gnt_data;
  int                       scan_start;

  logic                     we_q;
  logic [ADDR_WIDTH-1:0]    waddr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [1:0]               gid_q;
  logic [NUM_REGISTERS-1:0] busy_q, busy_d, set_vec, clr_vec;

`ifdef W0RM_WB_ARB_FIXED_PRIORITY_EN
  assign scan_start = 0;
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;
  assign scan_start = int'(rr_ptr_q);
  assign rr_ptr_d   = gnt_found ? 2'((int'(gnt_idx) + 1) % NUM_REQ) : rr_ptr_q;
`endif

  // First valid requester found scanning upward from scan_start, wrapping.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_addr   = '0;
    gnt_data   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_found && !reset && req_valid[i] && (i == (scan_start + k) % NUM_REQ)) begin
          gnt_found     = 1'b1;
          gnt_onehot[i] = 1'b1;
          gnt_idx       = 2'(i);
          gnt_addr      = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          gnt_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign req_ready = gnt_onehot;

  // Set is applied after clear so a same-cycle reservation survives the write.
  assign set_vec = rsv_valid ? (REG_LSB << rsv_addr) : '0;
  assign clr_vec = gnt_found ? (REG_LSB << gnt_addr) : '0;
  assign busy_d  = (busy_q & ~clr_vec) | set_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      gid_q    <= '0;
      busy_q   <= '0;
`ifndef W0RM_WB_ARB_FIXED_PRIORITY_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      we_q   <= gnt_found;
      busy_q <= busy_d;
      if (gnt_found) begin
        waddr_q <= gnt_addr;
        wdata_q <= gnt_data;
        gid_q   <= gnt_idx;
      end
`ifndef W0RM_WB_ARB_FIXED_PRIORITY_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;
  assign grant_id        = gid_q;
  assign busy_mask       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_w0rm_core_regfile_wb_arbiter.sv
`default_nettype none
// Directed and random stimulus for w0rm_core_regfile_wb_arbiter (round-robin build),
// checked every cycle against a queue-free behavioural model plus literal expectations.
module tb_w0rm_core_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [3:0]  a [3];
  logic [31:0] d [3];
  logic [11:0] req_addr;
  logic [95:0] req_data;
  logic        rsv_valid = 1'b0;
  logic [3:0]  rsv_addr = '0;
  logic        rf_write_enable;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [1:0]  grant_id;
  logic [15:0] busy_mask;

  int total = 0;
  int bad   = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  w0rm_core_regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .grant_id(grant_id), .busy_mask(busy_mask)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain rules -- first valid index from the pointer wins, write lands a cycle later.
  int          m_ptr = 0;
  bit          m_ok = 1'b0;
  logic        m_we;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_gid;
  logic [15:0] m_busy;
  int          g;
  int          gn;
  logic [2:0]  exp_rdy;

  function automatic int scan(input int ptr, input logic [2:0] v);
    for (int k = 0; k < 3; k++) begin
      if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_we = 1'b0; m_addr = '0; m_data = '0; m_gid = '0; m_busy = '0; m_ptr = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      g = scan(m_ptr, req_valid);
      if (g >= 0) begin
        m_busy[a[g]] = 1'b0;
        m_we   = 1'b1;
        m_addr = a[g];
        m_data = d[g];
        m_gid  = 2'(g);
        m_ptr  = (g + 1) % 3;
      end else begin
        m_we = 1'b0;
      end
      if (rsv_valid) m_busy[rsv_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      gn = scan(m_ptr, req_valid);
      exp_rdy = (reset || gn < 0) ? 3'b000 : 3'(1 << gn);
      chk("m_ready", {61'd0, req_ready}, {61'd0, exp_rdy});
      chk("m_ready_onehot0", {63'd0, $onehot0(req_ready)}, 64'd1);
      chk("m_ready_no_valid", {61'd0, req_ready & ~req_valid}, 64'd0);
      chk("m_we", {63'd0, rf_write_enable}, {63'd0, m_we});
      chk("m_addr", {60'd0, rf_write_addr}, {60'd0, m_addr});
      chk("m_data", {32'd0, rf_write_data}, {32'd0, m_data});
      chk("m_gid", {62'd0, grant_id}, {62'd0, m_gid});
      chk("m_busy", {48'd0, busy_mask}, {48'd0, m_busy});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_seq [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; end
    tick(); tick();
    chk("rst_we", {63'd0, rf_write_enable}, 64'd0);
    chk("rst_busy", {48'd0, busy_mask}, 64'd0);
    chk("rst_ready", {61'd0, req_ready}, 64'd0);
    chk("rst_data", {32'd0, rf_write_data}, 64'd0);

    // Single requester after reservation of r3
    reset = 1'b0; rsv_valid = 1'b1; rsv_addr = 4'd3;
    tick();
    chk("rsv_busy3", {48'd0, busy_mask}, 64'h0008);
    rsv_valid = 1'b0; req_valid = 3'b001; a[0] = 4'd3; d[0] = 32'h0000_00A5;
    #1;
    chk("single_ready", {61'd0, req_ready}, 64'h1);
    tick();
    req_valid = 3'b000;
    chk("single_we", {63'd0, rf_write_enable}, 64'd1);
    chk("single_addr", {60'd0, rf_write_addr}, 64'd3);
    chk("single_data", {32'd0, rf_write_data}, 64'hA5);
    chk("single_gid", {62'd0, grant_id}, 64'd0);
    chk("single_busy", {48'd0, busy_mask}, 64'd0);

    // All three valid from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0; req_valid = 3'b111;
    a[0] = 4'd1; a[1] = 4'd2; a[2] = 4'd3;
    d[0] = 32'hAAAA_0000; d[1] = 32'hBBBB_0001; d[2] = 32'hCCCC_0002;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("rr_we", {63'd0, rf_write_enable}, 64'd1);
      chk("rr_gid", {62'd0, grant_id}, 64'(exp_seq[j]));
    end

    // Move the pointer to 2, then contend 1 vs 2
    req_valid = 3'b010;
    tick();
    req_valid = 3'b110; d[1] = 32'h1111_0001; d[2] = 32'h2222_0002;
    tick();
    chk("p2_gid", {62'd0, grant_id}, 64'd2);
    chk("p2_data", {32'd0, rf_write_data}, 64'h2222_0002);
    req_valid = 3'b010;
    tick();
    chk("p2_gid1", {62'd0, grant_id}, 64'd1);
    chk("p2_data1", {32'd0, rf_write_data}, 64'h1111_0001);
    req_valid = 3'b000;
    tick();
    chk("idle_we", {63'd0, rf_write_enable}, 64'd0);
    chk("idle_hold", {32'd0, rf_write_data}, 64'h1111_0001);

    // Same-cycle reserve and write of r5
    req_valid = 3'b001; a[0] = 4'd5; rsv_valid = 1'b1; rsv_addr = 4'd5;
    tick();
    chk("setwins_busy", {48'd0, busy_mask}, 64'h0020);
    req_valid = 3'b000; rsv_valid = 1'b0;
    tick();
    chk("setwins_hold", {48'd0, busy_mask}, 64'h0020);

    // Reset the cycle after an accept
    req_valid = 3'b001; a[0] = 4'd9; d[0] = 32'h0000_0099; rsv_valid = 1'b1; rsv_addr = 4'd3;
    tick();
    chk("pre_rst_busy", {48'd0, busy_mask}, 64'h0028);
    chk("pre_rst_we", {63'd0, rf_write_enable}, 64'd1);
    reset = 1'b1; req_valid = 3'b111; rsv_valid = 1'b0;
    #1;
    chk("rst_mid_ready", {61'd0, req_ready}, 64'd0);
    tick();
    chk("rst_mid_we", {63'd0, rf_write_enable}, 64'd0);
    chk("rst_mid_busy", {48'd0, busy_mask}, 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_gid", {62'd0, grant_id}, 64'd0);
    chk("post_rst_we", {63'd0, rf_write_enable}, 64'd1);

    // Random traffic, checked by the model every cycle
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      req_valid = 3'($urandom_range(0, 7));
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 4'($urandom_range(0, 15));
      for (int i = 0; i < 3; i++) begin
        a[i] = 4'($urandom_range(0, 15));
        d[i] = $urandom;
      end
      tick();
    end
    reset = 1'b0; req_valid = '0; rsv_valid = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
